// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//  Shared definitions for the bit-serial adder: the controller FSM state encoding.
package serial_adder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if
//  Handshake/data bundle between a controller and the bit-serial adder.
//  master : drives start, a_in, b_in, cin; observes busy, done, sum, cout
//  slave  : the adder side (inverse directions)
interface serial_adder_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a_in, b_in, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a_in, b_in, cin,
    output busy, done, sum, cout
  );

endinterface

// File: rtl/my_FA.sv
// my_FA
//  One-bit combinational full-adder cell.
//  Ports: Cin, A, B (in)  -> R = A ^ B ^ Cin, Cout = majority(A, B, Cin) (out)
module my_FA (
  input  logic Cin,
  input  logic A,
  input  logic B,
  output logic R,
  output logic Cout
);

  assign R    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//  Bit-serial WIDTH-bit adder: a single full-adder cell plus a carry flip-flop
//  processes one bit per clock, LSB first. A start/busy/done handshake frames
//  each WIDTH-cycle addition; sum/cout are registered and only change when a
//  result completes.
//  Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - serial_adder_if.slave: start, a_in, b_in, cin (in);
//          busy, done, sum, cout (out)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  serial_adder_if.slave  bus
);

  localparam int                 CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state_reg;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [WIDTH-1:0]   a_sh_reg;
  logic [WIDTH-1:0]   b_sh_reg;
  // Only WIDTH-1 partial-sum bits need storing; the final bit comes straight
  // from the adder cell on the completing edge.
  logic [WIDTH-2:0]   sum_sh_reg;
  logic               carry_reg;
  logic [WIDTH-1:0]   sum_reg;
  logic               cout_reg;
  logic               done_reg;

  logic               fa_r;
  logic               fa_cout;
  logic [WIDTH-1:0]   sum_word;
  logic               accept;
  logic               last_bit;

  my_FA u_fa (
    .Cin  (carry_reg),
    .A    (a_sh_reg[0]),
    .B    (b_sh_reg[0]),
    .R    (fa_r),
    .Cout (fa_cout)
  );

  // Newest result bit enters at the top, so after WIDTH shifts bit 0 is the LSB.
  assign sum_word = {fa_r, sum_sh_reg};
  assign accept   = (state_reg == IDLE) && bus.start;
  assign last_bit = (state_reg == RUN) && (cnt_reg == CNT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (cnt_reg == CNT_LAST) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    bus.busy = 1'b0;
    case (state_reg)
      RUN:     bus.busy = 1'b1;
      default: bus.busy = 1'b0;
    endcase
  end

  assign bus.done = done_reg;
  assign bus.sum  = sum_reg;
  assign bus.cout = cout_reg;

  // Datapath: operand shifters, carry FF, bit counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg    <= '0;
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      sum_sh_reg <= '0;
      carry_reg  <= 1'b0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        a_sh_reg   <= bus.a_in;
        b_sh_reg   <= bus.b_in;
        carry_reg  <= bus.cin;
        cnt_reg    <= '0;
        sum_sh_reg <= '0;
      end else if (state_reg == RUN) begin
        sum_sh_reg <= sum_word[WIDTH-1:1];
        carry_reg  <= fa_cout;
        a_sh_reg   <= {1'b0, a_sh_reg[WIDTH-1:1]};
        b_sh_reg   <= {1'b0, b_sh_reg[WIDTH-1:1]};
        if (last_bit) begin
          // Counter parks at WIDTH-1; the next accept reloads it.
          sum_reg  <= sum_word;
          cout_reg <= fa_cout;
          done_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//  Scoreboard bench: an 8-bit and a 4-bit adder share clk/rst. Stimulus pushes
//  expected {cout,sum} and due cycle into queues; per-DUT monitors pop and
//  compare whenever done is seen, and check result hold otherwise.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(4)) if4 ();

  serial_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  serial_adder #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

  logic [8:0] exp8_q[$];
  int         due8_q[$];
  logic [4:0] exp4_q[$];
  int         due4_q[$];
  logic [8:0] last8 = '0;
  logic [4:0] last4 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- monitors ----------------
  initial begin : mon8
    logic prev = 1'b0;
    logic [8:0] e;
    int d;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else if (if8.done) begin
        chk("w8_done_single_cycle", {31'd0, prev}, 32'd0);
        if (exp8_q.size() == 0) begin
          chk("w8_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp8_q.pop_front();
          d = due8_q.pop_front();
          chk("w8_result", {23'd0, if8.cout, if8.sum}, {23'd0, e});
          chk("w8_latency", cyc, d);
          $display("w8 result cout=%b sum=%h expected=%h cycle=%0d", if8.cout, if8.sum, e, cyc);
          last8 = e;
        end
        prev = 1'b1;
      end else begin
        chk("w8_hold", {23'd0, if8.cout, if8.sum}, {23'd0, last8});
        prev = 1'b0;
      end
    end
  end

  initial begin : mon4
    logic prev = 1'b0;
    logic [4:0] e;
    int d;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b0;
      end else if (if4.done) begin
        chk("w4_done_single_cycle", {31'd0, prev}, 32'd0);
        if (exp4_q.size() == 0) begin
          chk("w4_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp4_q.pop_front();
          d = due4_q.pop_front();
          chk("w4_result", {27'd0, if4.cout, if4.sum}, {27'd0, e});
          chk("w4_latency", cyc, d);
          $display("w4 result cout=%b sum=%h expected=%h cycle=%0d", if4.cout, if4.sum, e, cyc);
          last4 = e;
        end
        prev = 1'b1;
      end else begin
        chk("w4_hold", {27'd0, if4.cout, if4.sum}, {27'd0, last4});
        prev = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers (called at posedge+#1) ----------------
  task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input logic [8:0] e, input logic hold_start);
    int n = 0;
    while (if8.busy === 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("w8_idle_timeout", 32'd1, 32'd0);
    if8.a_in  = a;
    if8.b_in  = b;
    if8.cin   = c;
    if8.start = 1'b1;
    @(posedge clk); #1;
    exp8_q.push_back(e);
    due8_q.push_back(cyc + 8);
    chk("w8_busy_after_accept", {31'd0, if8.busy}, 32'd1);
    if (!hold_start) if8.start = 1'b0;
    // Operands changing while busy must not disturb the running addition.
    if8.a_in = 8'($urandom);
    if8.b_in = 8'($urandom);
    if8.cin  = 1'($urandom);
  endtask

  task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic c);
    int n = 0;
    while (if4.busy === 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("w4_idle_timeout", 32'd1, 32'd0);
    if4.a_in  = a;
    if4.b_in  = b;
    if4.cin   = c;
    if4.start = 1'b1;
    @(posedge clk); #1;
    exp4_q.push_back(5'(a) + 5'(b) + 5'(c));
    due4_q.push_back(cyc + 4);
    if4.start = 1'b0;
  endtask

  task automatic drain;
    int n = 0;
    while ((exp8_q.size() != 0 || exp4_q.size() != 0) && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 300) chk("drain_timeout", 32'd1, 32'd0);
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic check_zero8(input string tag);
    chk({tag, "_busy"}, {31'd0, if8.busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, if8.done}, 32'd0);
    chk({tag, "_sum"},  {24'd0, if8.sum},  32'd0);
    chk({tag, "_cout"}, {31'd0, if8.cout}, 32'd0);
  endtask

  // Directed WIDTH=8 vectors: a, b, cin, hand-computed {cout,sum}
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [8:0] e;
  } vec_t;

  vec_t vecs[8] = '{
    '{8'h35, 8'h4A, 1'b0, 9'h07F},
    '{8'hFF, 8'h01, 1'b0, 9'h100},
    '{8'hFF, 8'hFF, 1'b1, 9'h1FF},
    '{8'h00, 8'h00, 1'b1, 9'h001},
    '{8'h80, 8'h80, 1'b0, 9'h100},
    '{8'h0F, 8'hF0, 1'b1, 9'h100},
    '{8'hA5, 8'h5A, 1'b0, 9'h0FF},
    '{8'h12, 8'h34, 1'b1, 9'h047}
  };

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    if8.start = 1'b0; if8.a_in = '0; if8.b_in = '0; if8.cin = 1'b0;
    if4.start = 1'b0; if4.a_in = '0; if4.b_in = '0; if4.cin = 1'b0;
    rst = 1'b1;
    #1;
    check_zero8("por8");
    chk("por4_busy", {31'd0, if4.busy}, 32'd0);
    chk("por4_done", {31'd0, if4.done}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;

    // Directed operands, one pulse each
    foreach (vecs[i]) issue8(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].e, 1'b0);
    drain();

    // Stray start pulse mid-run must be ignored
    issue8(8'h21, 8'h43, 1'b0, 9'h064, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    if8.a_in = 8'h11; if8.b_in = 8'h22; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    drain();

    // Start held high continuously: back-to-back accepts
    issue8(8'h01, 8'h02, 1'b0, 9'h003, 1'b1);
    issue8(8'h7F, 8'h01, 1'b0, 9'h080, 1'b1);
    issue8(8'hC8, 8'h64, 1'b1, 9'h12D, 1'b1);
    if8.start = 1'b0;
    drain();

    // Reset in the middle of a run: aborts, outputs clear asynchronously
    issue8(8'h55, 8'h22, 1'b0, 9'h077, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    #1 rst = 1'b1;
    #1;
    check_zero8("midrst8");
    exp8_q.delete(); due8_q.delete();
    exp4_q.delete(); due4_q.delete();
    last8 = '0; last4 = '0;
    @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    issue8(8'h10, 8'h20, 1'b0, 9'h030, 1'b0);
    drain();

    // WIDTH=4 exhaustive against the golden a+b+cin
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          issue4(4'(a), 4'(b), 1'(c));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
